// File: rtl/sig_pkg.sv
// Shared light, phase and violation codes for the traffic-light controller and its protocol monitor.
package sig_pkg;

    localparam int unsigned LIGHT_W = 2;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIM_W   = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [LIGHT_W-1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [PHASE_W-1:0] {
        S0  = 3'd0,
        S1  = 3'd1,
        S2  = 3'd2,
        S3  = 3'd3,
        S4  = 3'd4,
        ILL = 3'd7
    } phase_t;

    typedef enum logic [CODE_W-1:0] {
        ERR_NONE          = 2'd0,
        ERR_ILLEGAL_COMBO = 2'd1,
        ERR_BAD_SEQ       = 2'd2,
        ERR_BAD_DWELL     = 2'd3
    } err_code_t;

    // Only legal successor of each legal phase; ILL has none.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            S0:      return S1;
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S0;
            default: return ILL;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sig_light_decode.sv
// Maps a highway/country light pair onto the controller phase it represents.
module sig_light_decode
    import sig_pkg::*;
(
    input  logic [LIGHT_W-1:0] hwy,
    input  logic [LIGHT_W-1:0] cntry,
    output logic [PHASE_W-1:0] phase_c
);

    always_comb begin
        phase_c = ILL;
        case ({hwy, cntry})
            {GREEN,  RED}:    phase_c = S0;
            {YELLOW, RED}:    phase_c = S1;
            {RED,    RED}:    phase_c = S2;
            {RED,    GREEN}:  phase_c = S3;
            {RED,    YELLOW}: phase_c = S4;
            default:          phase_c = ILL;
        endcase
    end

endmodule

// File: rtl/sig_monitor.sv
// Passive protocol monitor for the highway/country traffic-light controller:
// decodes the phase, checks sequence and dwell rules, and gathers cycle/wait statistics.
module sig_monitor
    import sig_pkg::*;
#(
    parameter int unsigned Y2RDELAY = 3,
    parameter int unsigned R2GDELAY = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [LIGHT_W-1:0]   hwy,
    input  logic [LIGHT_W-1:0]   cntry,
    input  logic                 X,
    output logic [PHASE_W-1:0]   phase,
    output logic                 err,
    output logic [CODE_W-1:0]    err_code,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     wait_max
);

    localparam logic [LIM_W-1:0] Y2R_LIM = LIM_W'(Y2RDELAY);
    localparam logic [LIM_W-1:0] R2G_LIM = LIM_W'(R2GDELAY);

    logic [PHASE_W-1:0] dec_c;
    phase_t             new_c;
    phase_t             cur_q;
    logic               x_q;
    logic               first_q;
    logic [CNT_W-1:0]   dwell_q;
    logic [CNT_W-1:0]   wait_q;
    logic               arm_q;

    logic               change_c;
    logic               timed_c;
    logic [LIM_W-1:0]   lim_c;
    logic [LIM_W-1:0]   dwell_inc_c;
    logic               ill_c;
    logic               seq_c;
    logic               dwl_c;
    err_code_t          code_c;
    logic [CNT_W-1:0]   wait_nxt_c;
    logic               arm_nxt_c;
    logic [CNT_W-1:0]   wmax_nxt_c;
    logic [CNT_W-1:0]   cyc_nxt_c;

    sig_light_decode u_decode (
        .hwy     (hwy),
        .cntry   (cntry),
        .phase_c (dec_c)
    );

    assign new_c = phase_t'(dec_c);
    assign phase = cur_q;

    // Violation detection: the incoming sample against the held phase and its dwell.
    always_comb begin
        change_c    = (new_c != cur_q);
        dwell_inc_c = {1'b0, dwell_q} + LIM_W'(1);
        timed_c     = 1'b0;
        lim_c       = '0;
        ill_c       = (new_c == ILL);
        seq_c       = 1'b0;
        dwl_c       = 1'b0;

        if (cur_q == S1 || cur_q == S4) begin
            timed_c = 1'b1;
            lim_c   = Y2R_LIM;
        end else if (cur_q == S2) begin
            timed_c = 1'b1;
            lim_c   = R2G_LIM;
        end

        // The first sample after clear has no previous phase to compare against.
        if (!first_q) begin
            if (change_c && cur_q != ILL && new_c != ILL && new_c != next_phase(cur_q)) begin
                seq_c = 1'b1;
            end
            if (cur_q == S0 && new_c == S1 && !x_q) begin
                seq_c = 1'b1;
            end
            if (cur_q == S3 && new_c == S4 && x_q) begin
                seq_c = 1'b1;
            end
            if (timed_c) begin
                if (change_c) begin
                    dwl_c = ({1'b0, dwell_q} != lim_c);
                end else begin
                    dwl_c = (dwell_inc_c == lim_c + LIM_W'(1));
                end
            end
        end

        if (ill_c) begin
            code_c = ERR_ILLEGAL_COMBO;
        end else if (seq_c) begin
            code_c = ERR_BAD_SEQ;
        end else if (dwl_c) begin
            code_c = ERR_BAD_DWELL;
        end else begin
            code_c = ERR_NONE;
        end
    end

    // Wait measurement: cycles X stays high in S0, published to wait_max on S3 entry.
    always_comb begin
        wait_nxt_c = wait_q;
        arm_nxt_c  = arm_q;
        wmax_nxt_c = wait_max;
        cyc_nxt_c  = cycle_cnt;

        if (new_c == S0) begin
            if (!X) begin
                arm_nxt_c  = 1'b0;
                wait_nxt_c = '0;
            end else if (arm_q && cur_q == S0 && !first_q) begin
                wait_nxt_c = sat_inc(wait_q);
            end else begin
                arm_nxt_c  = 1'b1;
                wait_nxt_c = '0;
            end
        end else if (arm_q && cur_q == S0 && !first_q) begin
            // The last S0 cycle completes on departure.
            wait_nxt_c = sat_inc(wait_q);
        end

        if (!first_q && arm_q && new_c == S3 && cur_q != S3) begin
            arm_nxt_c = 1'b0;
            if (wait_nxt_c > wait_max) begin
                wmax_nxt_c = wait_nxt_c;
            end
        end

        if (!first_q && cur_q == S4 && new_c == S0) begin
            cyc_nxt_c = sat_inc(cycle_cnt);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cur_q     <= S0;
            x_q       <= 1'b0;
            first_q   <= 1'b1;
            dwell_q   <= '0;
            wait_q    <= '0;
            arm_q     <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            cycle_cnt <= '0;
            wait_max  <= '0;
        end else begin
            cur_q     <= new_c;
            x_q       <= X;
            first_q   <= 1'b0;
            dwell_q   <= (first_q || change_c) ? CNT_W'(1) : sat_inc(dwell_q);
            wait_q    <= wait_nxt_c;
            arm_q     <= arm_nxt_c;
            cycle_cnt <= cyc_nxt_c;
            wait_max  <= wmax_nxt_c;
            // Only the first violation is recorded; err is sticky until clear.
            if (!err && (ill_c || seq_c || dwl_c)) begin
                err      <= 1'b1;
                err_code <= code_c;
            end
        end
    end

endmodule

// File: tb/tb_sig_monitor.sv
// Self-checking bench for sig_monitor: directed scenarios plus randomized phase walks
// compared against a sample-level reference model.
module tb_sig_monitor;

    localparam int Y2R = 3;
    localparam int R2G = 2;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] hwy   = 2'd0;
    logic [1:0] cntry = 2'd0;
    logic       X     = 1'b0;
    logic [2:0] phase;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] cycle_cnt;
    logic [7:0] wait_max;

    int n_vec = 0;
    int n_bad = 0;

    // Light pair shown in each legal phase (index = phase code).
    int h_of [5] = '{2, 1, 0, 0, 0};
    int c_of [5] = '{0, 0, 0, 2, 1};

    // Reference model state
    int m_phase, m_err, m_code, m_cyc, m_wmax;
    int have_prev, prev_p, prev_x, m_dwell, run_len, run_act;

    sig_monitor #(.Y2RDELAY(Y2R), .R2GDELAY(R2G)) dut (
        .clock     (clock),
        .clear     (clear),
        .hwy       (hwy),
        .cntry     (cntry),
        .X         (X),
        .phase     (phase),
        .err       (err),
        .err_code  (err_code),
        .cycle_cnt (cycle_cnt),
        .wait_max  (wait_max)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input int h, input int c);
        for (int p = 0; p < 5; p++) begin
            if (h_of[p] == h && c_of[p] == c) return p;
        end
        return 7;
    endfunction

    function automatic int limit_of(input int p);
        if (p == 1 || p == 4) return Y2R;
        if (p == 2) return R2G;
        return 0;
    endfunction

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_err = 0; m_code = 0; m_cyc = 0; m_wmax = 0;
        have_prev = 0; prev_p = 0; prev_x = 0; m_dwell = 0; run_len = 0; run_act = 0;
    endtask

    task automatic model_step(input int p, input int x);
        int ill, seq, dw;
        ill = (p == 7);
        seq = 0;
        dw  = 0;
        if (have_prev != 0) begin
            if (p != prev_p) begin
                if (prev_p != 7 && p != 7 && p != (prev_p + 1) % 5) seq = 1;
                if (prev_p == 0 && p == 1 && prev_x == 0) seq = 1;
                if (prev_p == 3 && p == 4 && prev_x != 0) seq = 1;
                if (limit_of(prev_p) > 0 && m_dwell != limit_of(prev_p)) dw = 1;
                if (prev_p == 4 && p == 0) m_cyc = min255(m_cyc + 1);
                if (p == 3 && run_act != 0) begin
                    if (min255(run_len) > m_wmax) m_wmax = min255(run_len);
                    run_act = 0;
                end
                m_dwell = 1;
            end else begin
                m_dwell++;
                if (limit_of(p) > 0 && m_dwell == limit_of(p) + 1) dw = 1;
            end
        end else begin
            m_dwell = 1;
        end
        // Wait = length of the X-high run in S0 that precedes departure.
        if (p == 0) begin
            if (x != 0) begin
                if (have_prev != 0 && prev_p == 0 && run_act != 0) run_len++;
                else begin run_len = 1; run_act = 1; end
            end else begin
                run_act = 0;
            end
        end
        if (m_err == 0 && (ill || seq || dw)) begin
            m_err  = 1;
            m_code = ill ? 1 : (seq ? 2 : 3);
        end
        m_phase = p; have_prev = 1; prev_p = p; prev_x = x;
    endtask

    task automatic apply(input int h, input int c, input int x);
        hwy   = 2'(h);
        cntry = 2'(c);
        X     = 1'(x);
        model_step(decode(h, c), x);
        @(negedge clock);
        check("phase",     int'(phase),     m_phase);
        check("err",       int'(err),       m_err);
        check("err_code",  int'(err_code),  m_code);
        check("cycle_cnt", int'(cycle_cnt), m_cyc);
        check("wait_max",  int'(wait_max),  m_wmax);
    endtask

    task automatic put(input int p, input int x);
        apply(h_of[p], c_of[p], x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 clear = 1'b0;
        #1;
        check("rst_phase",     int'(phase),     0);
        check("rst_err",       int'(err),       0);
        check("rst_err_code",  int'(err_code),  0);
        check("rst_cycle_cnt", int'(cycle_cnt), 0);
        check("rst_wait_max",  int'(wait_max),  0);
        model_reset();
        @(negedge clock);
        clear = 1'b1;
    endtask

    // One legal controller cycle starting and ending in S0.
    task automatic legal_cycle(input int xw, input int s3_len);
        put(0, 0);
        repeat (xw) put(0, 1);
        repeat (Y2R) put(1, 0);
        repeat (R2G) put(2, 0);
        repeat (s3_len) put(3, 0);
        repeat (Y2R) put(4, 0);
        put(0, 0);
    endtask

    initial begin
        int p, r;
        model_reset();
        do_reset();

        // Default legal cycle
        legal_cycle(5, 2);
        check("legal_err",  int'(err),       0);
        check("legal_cyc",  int'(cycle_cnt), 1);
        check("legal_wmax", int'(wait_max),  5);
        legal_cycle(2, 1);
        check("legal_wmax_keep", int'(wait_max), 5);

        // Illegal light combination, then a later dwell violation
        do_reset();
        put(0, 1);
        apply(2, 2, 1);
        check("ill_phase", int'(phase),    7);
        check("ill_code",  int'(err_code), 1);
        put(0, 1);
        repeat (4) put(1, 0);
        check("ill_code_kept", int'(err_code), 1);

        // Yellow overstay flagged on the 4th dwell cycle
        do_reset();
        put(0, 1);
        repeat (3) put(1, 0);
        check("s1_three_ok", int'(err), 0);
        put(1, 0);
        check("s1_over_err",  int'(err),      1);
        check("s1_over_code", int'(err_code), 3);

        // Skipped phase, and S0->S1 without a car waiting
        do_reset();
        put(0, 1);
        put(2, 0);
        check("skip_code", int'(err_code), 2);
        do_reset();
        put(0, 1);
        put(0, 0);
        put(1, 0);
        check("nocar_code", int'(err_code), 2);

        // Saturation of cycle_cnt
        do_reset();
        repeat (260) legal_cycle(1, 1);
        check("sat_cyc", int'(cycle_cnt), 255);
        legal_cycle(1, 1);
        check("sat_cyc_hold", int'(cycle_cnt), 255);

        // Clear in the middle of S2, then a clean cycle
        do_reset();
        put(0, 1);
        repeat (Y2R) put(1, 0);
        put(2, 0);
        do_reset();
        legal_cycle(3, 2);
        check("midrst_err",  int'(err),       0);
        check("midrst_cyc",  int'(cycle_cnt), 1);
        check("midrst_wmax", int'(wait_max),  3);

        // Randomized walks through the phase sequence with occasional faults
        for (int b = 0; b < 12; b++) begin
            do_reset();
            p = 0;
            for (int k = 0; k < 50; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 3) begin
                    apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 1)));
                end else begin
                    if (r < 8) p = int'($urandom_range(0, 4));
                    else if (r >= 55) p = (p + 1) % 5;
                    put(p, (p == 0) ? int'($urandom_range(0, 3) != 0)
                                    : int'($urandom_range(0, 4) == 0));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
